// File: rtl/bg_image_writer.sv
// Background-picture SDRAM write path: packs ioctl bytes into 16-bit words, queues them
// in a small FIFO and writes them to SDRAM over req/ack, flagging when the image is resident.
//
// state  | meaning
// S_INIT | waiting for the SDRAM controller to finish init
// S_IDLE | no write outstanding; issue the FIFO head when one exists
// S_REQ  | write request held until mem_ack
module bg_image_writer #(
    parameter int ADDR_W   = 25,
    parameter int DEPTH    = 4,
    parameter int BG_INDEX = 2
) (
    input  logic              clk_25,
    input  logic              RESET_L,
    input  logic              dl_active,
    input  logic [7:0]        dl_index,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              sdram_present,
    input  logic              mem_ready,
    input  logic              mem_ack,
    output logic              dl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              bg_valid,
    output logic              overflow,
    output logic [23:0]       words_written
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W + 16;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ} state_t;

    state_t              state, state_nxt;
    logic                sel, sel_d, start, dl_end, byte_wr, pend_eff;
    logic                pending, end_seen;
    logic [7:0]          lo;
    logic [ADDR_W-1:0]   lo_addr;
    logic                push, accept, pop, load;
    logic [WORD_W-1:0]   push_word;
    logic [WORD_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                empty, full;

    assign sel      = dl_active & (dl_index == 8'(BG_INDEX)) & sdram_present;
    assign start    = sel & ~sel_d;
    assign dl_end   = sel_d & ~dl_active;
    assign byte_wr  = dl_wr & sel;
    assign pend_eff = pending & ~start;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign dl_wait = (count >= CNT_W'(DEPTH - 1));

    // A pending even byte is flushed with hi=0 when another even byte or the download end arrives.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (dl_end && pending) begin
            push      = 1'b1;
            push_word = {lo_addr, 8'h00, lo};
        end else if (byte_wr) begin
            if (dl_addr[0]) begin
                push      = 1'b1;
                push_word = {dl_addr[ADDR_W-1:1], 1'b0, dl_data, (pend_eff ? lo : 8'h00)};
            end else if (pend_eff) begin
                push      = 1'b1;
                push_word = {lo_addr, 8'h00, lo};
            end
        end
    end

    assign accept = push & (~full | pop);

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            sel_d    <= 1'b0;
            pending  <= 1'b0;
            lo       <= '0;
            lo_addr  <= '0;
            end_seen <= 1'b0;
        end else begin
            sel_d <= sel;
            if (byte_wr) begin
                pending <= ~dl_addr[0];
                if (!dl_addr[0]) begin
                    lo      <= dl_data;
                    lo_addr <= dl_addr;
                end
            end else if (start || dl_end) begin
                pending <= 1'b0;
            end
            if (start)
                end_seen <= 1'b0;
            else if (dl_end)
                end_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (accept)
            fifo_mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !accept)
                overflow <= 1'b1;
            else if (start)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            S_INIT: if (mem_ready) state_nxt = S_IDLE;
            S_IDLE: if (!empty) begin
                load      = 1'b1;
                state_nxt = S_REQ;
            end
            S_REQ: if (mem_ack) begin
                pop       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            words_written <= '0;
            bg_valid      <= 1'b0;
        end else begin
            if (load) begin
                mem_req  <= 1'b1;
                mem_addr <= fifo_mem[rd_ptr][WORD_W-1:16];
                mem_din  <= fifo_mem[rd_ptr][15:0];
            end else if (pop) begin
                mem_req <= 1'b0;
            end
            if (start)
                words_written <= '0;
            else if (pop && !(&words_written))
                words_written <= words_written + 24'd1;
            bg_valid <= ~start & end_seen & empty & (state == S_IDLE)
                        & (words_written != '0) & ~overflow;
        end
    end
endmodule

// File: tb/tb_bg_image_writer.sv
// Bench for bg_image_writer: directed cases plus random downloads against a byte-to-word
// reference model, with a randomized SDRAM responder.
module tb_bg_image_writer;
    logic        clk_25 = 1'b0;
    logic        RESET_L = 1'b0;
    logic        dl_active = 1'b0;
    logic [7:0]  dl_index = 8'd0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = 8'd0;
    logic        sdram_present = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_ack = 1'b0;
    logic        dl_wait, mem_req, bg_valid, overflow;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic [23:0] words_written;

    int checks = 0;
    int errors = 0;
    int ack_lat_cfg = 0;
    int req_count = 0;
    bit saw_wait = 0;

    logic [24:0] b_addr[$];
    logic [7:0]  b_data[$];
    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];

    bg_image_writer #(.ADDR_W(25), .DEPTH(4), .BG_INDEX(2)) dut (
        .clk_25(clk_25), .RESET_L(RESET_L), .dl_active(dl_active), .dl_index(dl_index),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .sdram_present(sdram_present),
        .mem_ready(mem_ready), .mem_ack(mem_ack), .dl_wait(dl_wait), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_din(mem_din), .bg_valid(bg_valid), .overflow(overflow),
        .words_written(words_written)
    );

    always #20 clk_25 = ~clk_25;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM side: ack each request after a configurable or random delay, checking stability.
    always begin : responder
        bit          req_seen;
        int          lat;
        logic [40:0] held;
        @(posedge clk_25); #1;
        if (!RESET_L) begin
            req_seen = 0;
            mem_ack  = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (!req_seen) begin
                req_seen = 1;
                req_count++;
                held = {mem_addr, mem_din};
                lat  = (ack_lat_cfg < 0) ? int'($urandom_range(0, 5)) : ack_lat_cfg;
            end else begin
                chk("req_stable", 64'({mem_addr, mem_din}), 64'(held));
            end
            if (lat == 0) begin
                mem_ack = 1'b1;
                obs_q.push_back({mem_addr, mem_din});
                req_seen = 0;
            end else begin
                lat--;
            end
        end
    end

    // Reference: bytes pair up into words by address parity; orphan bytes get a zero partner.
    function automatic void build_exp();
        bit          pend = 0;
        logic [7:0]  lo = 8'd0;
        logic [24:0] la = '0;
        exp_q.delete();
        foreach (b_addr[i]) begin
            if (b_addr[i][0] == 1'b0) begin
                if (pend) exp_q.push_back({la, 8'h00, lo});
                pend = 1;
                lo   = b_data[i];
                la   = b_addr[i];
            end else begin
                exp_q.push_back({b_addr[i] & ~25'd1, b_data[i], (pend ? lo : 8'h00)});
                pend = 0;
            end
        end
        if (pend) exp_q.push_back({la, 8'h00, lo});
    endfunction

    task automatic tick();
        @(posedge clk_25); #1;
    endtask

    task automatic run_dl(input logic [7:0] idx, input logic pres, input bit honor_wait,
                          input int max_gap);
        int g;
        obs_q.delete();
        saw_wait = 0;
        dl_index = idx;
        sdram_present = pres;
        dl_active = 1'b1;
        tick();
        foreach (b_addr[i]) begin
            if (honor_wait) begin
                g = 0;
                while (dl_wait && g < 500) begin
                    saw_wait = 1;
                    tick();
                    g++;
                end
                if (g >= 500) chk("dl_wait_release", 64'(dl_wait), 64'd0);
            end
            dl_addr = b_addr[i];
            dl_data = b_data[i];
            dl_wr   = 1'b1;
            tick();
            dl_wr   = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
        dl_active = 1'b0;
        tick();
    endtask

    task automatic drain(input int n_exp);
        int g = 0;
        while (obs_q.size() < n_exp && g < 3000) begin
            tick();
            g++;
        end
        repeat (4) tick();
        chk("write_count", 64'(obs_q.size()), 64'(n_exp));
    endtask

    task automatic cmp_writes(input string tag);
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk(tag, 64'(obs_q[k]), 64'(exp_q[k]));
    endtask

    task automatic seq_bytes(input logic [24:0] base, input int n, input logic [7:0] d0);
        b_addr.delete();
        b_data.delete();
        for (int k = 0; k < n; k++) begin
            b_addr.push_back(base + 25'(k));
            b_data.push_back(d0 + 8'(k));
        end
    endtask

    initial begin
        int rc;
        logic [24:0] a;
        repeat (3) tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_outputs", 64'({dl_wait, bg_valid, overflow, words_written, mem_addr, mem_din}), 64'd0);
        RESET_L = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();

        // out-of-slot downloads: nothing written
        seq_bytes(25'd0, 4, 8'h10);
        rc = req_count;
        run_dl(8'd0, 1'b1, 1'b1, 0);
        repeat (20) tick();
        run_dl(8'd2, 1'b0, 1'b1, 0);
        repeat (20) tick();
        chk("no_slot_req", 64'(req_count - rc), 64'd0);
        chk("no_slot_valid", 64'(bg_valid), 64'd0);

        // 8 sequential bytes, ack one cycle after req
        ack_lat_cfg = 1;
        seq_bytes(25'd0, 8, 8'h00);
        build_exp();
        run_dl(8'd2, 1'b1, 1'b1, 0);
        drain(4);
        cmp_writes("t8_write");
        if (obs_q.size() == 4) begin
            chk("t8_first", 64'(obs_q[0]), 64'({25'd0, 16'h0100}));
            chk("t8_last", 64'(obs_q[3]), 64'({25'd6, 16'h0706}));
        end
        chk("t8_words", 64'(words_written), 64'd4);
        chk("t8_valid", 64'(bg_valid), 64'd1);
        chk("t8_ovf", 64'(overflow), 64'd0);

        // odd-length download: trailing byte padded with 0x00
        b_addr = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd4};
        b_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        build_exp();
        run_dl(8'd2, 1'b1, 1'b1, 0);
        drain(3);
        cmp_writes("t5_write");
        if (obs_q.size() == 3) chk("t5_last", 64'(obs_q[2]), 64'({25'd4, 16'h00EE}));
        chk("t5_words", 64'(words_written), 64'd3);
        chk("t5_valid", 64'(bg_valid), 64'd1);

        // push-to-request latency on an empty FIFO
        ack_lat_cfg = 0;
        obs_q.delete();
        dl_index = 8'd2; sdram_present = 1'b1; dl_active = 1'b1;
        tick();
        dl_addr = 25'd9; dl_data = 8'h5A; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        chk("lat_cycle1", 64'(mem_req), 64'd0);
        @(posedge clk_25); #1;
        chk("lat_cycle2", 64'(mem_req), 64'd1);
        dl_active = 1'b0;
        tick();
        drain(1);
        if (obs_q.size() == 1) chk("lat_word", 64'(obs_q[0]), 64'({25'd8, 16'h5A00}));
        chk("lat_valid", 64'(bg_valid), 64'd1);

        // slow SDRAM: backpressure must prevent any drop
        ack_lat_cfg = 20;
        seq_bytes(25'd100, 16, 8'h40);
        build_exp();
        run_dl(8'd2, 1'b1, 1'b1, 0);
        chk("slow_wait_seen", 64'(saw_wait), 64'd1);
        drain(8);
        cmp_writes("slow_write");
        chk("slow_ovf", 64'(overflow), 64'd0);
        chk("slow_words", 64'(words_written), 64'd8);
        chk("slow_valid", 64'(bg_valid), 64'd1);

        // backpressure ignored: 6 words into 4 slots
        ack_lat_cfg = 30;
        seq_bytes(25'd200, 12, 8'h80);
        run_dl(8'd2, 1'b1, 1'b0, 0);
        drain(4);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_words", 64'(words_written), 64'd4);
        chk("ovf_valid", 64'(bg_valid), 64'd0);

        // random downloads with irregular addressing
        ack_lat_cfg = -1;
        for (int it = 0; it < 8; it++) begin
            b_addr.delete();
            b_data.delete();
            a = 25'($urandom_range(0, 500)) & ~25'd1;
            for (int k = $urandom_range(1, 20); k > 0; k--) begin
                if ($urandom_range(0, 4) == 0) a = 25'($urandom_range(0, 1000));
                b_addr.push_back(a);
                b_data.push_back(8'($urandom));
                a = a + 25'd1;
            end
            build_exp();
            run_dl(8'd2, 1'b1, 1'b1, 2);
            drain(exp_q.size());
            cmp_writes("rnd_write");
            chk("rnd_words", 64'(words_written), 64'(exp_q.size()));
            chk("rnd_valid", 64'(bg_valid), 64'd1);
            chk("rnd_ovf", 64'(overflow), 64'd0);
        end

        // reset during an outstanding request, then wait for mem_ready again
        ack_lat_cfg = 50;
        seq_bytes(25'd0, 4, 8'h20);
        run_dl(8'd2, 1'b1, 1'b1, 0);
        chk("pre_rst_req", 64'(mem_req), 64'd1);
        mem_ready = 1'b0;
        RESET_L = 1'b0;
        #1;
        chk("rst_req_drop", 64'(mem_req), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        tick();
        RESET_L = 1'b1;
        ack_lat_cfg = 0;
        seq_bytes(25'd0, 2, 8'h31);
        rc = req_count;
        run_dl(8'd2, 1'b1, 1'b1, 0);
        repeat (10) tick();
        chk("init_hold", 64'(req_count - rc), 64'd0);
        mem_ready = 1'b1;
        drain(1);
        if (obs_q.size() == 1) chk("init_word", 64'(obs_q[0]), 64'({25'd0, 16'h3231}));
        chk("init_valid", 64'(bg_valid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
